registro_acumulador: RTL and testbench

REGISTRO_ACUMULADOR -- requirements
Module: registro_acumulador

---
 rtl/registro_acumulador.sv | 136 +++++++++++++
 tb/tb_registro_acumulador.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registro_acumulador.sv
// Signed load register / M-sample frame accumulator with a one-cycle ready pulse.
// Build option REGISTRO_SAT_EN: saturating sum plus sticky Desborde; otherwise the sum wraps.
module registro_acumulador #(
  parameter  int N  = 25,
  parameter  int M  = 8,
  localparam int CW = $clog2(M + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [2*N-1:0] Suma,
  input  logic                  Valid,
  input  logic                  Enable,
  input  logic                  Modo,
  output logic signed [2*N-1:0] Signreg,
  output logic [CW-1:0]         Cuenta,
  output logic                  Listo,
  output logic                  Desborde
);

  localparam int DATA_W = 2 * N;
  localparam logic [CW-1:0] M_CNT = CW'(M);

  typedef enum logic [1:0] {IDLE, ACUM, DONE} state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  reg_q;
  logic signed [DATA_W-1:0]  sum_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic                      listo_q;
  logic                      acc;

  assign acc   = Valid && !Enable;
  assign cnt_d = cnt_q + CW'(1);

`ifdef REGISTRO_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] sum_ext;
  logic                   ovf_d;
  logic                   desborde_q;

  function automatic logic signed [DATA_W:0] add_ext(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return {a[DATA_W-1], a} + {b[DATA_W-1], b};
  endfunction

  // A sign-extended sum whose top two bits disagree left the DATA_W-bit range.
  function automatic logic ovf_of(input logic signed [DATA_W:0] s);
    return s[DATA_W] ^ s[DATA_W-1];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_of(input logic signed [DATA_W:0] s);
    if (ovf_of(s)) return s[DATA_W] ? SAT_MIN : SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

  always_comb begin
    sum_ext = add_ext(reg_q, Suma);
    ovf_d   = ovf_of(sum_ext);
    sum_d   = sat_of(sum_ext);
  end

  assign Desborde = desborde_q;
`else
  function automatic logic signed [DATA_W-1:0] wrap_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_comb sum_d = wrap_add(reg_q, Suma);

  assign Desborde = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      listo_q <= 1'b0;
`ifdef REGISTRO_SAT_EN
      desborde_q <= 1'b0;
`endif
    end else begin
      // Listo is a single-cycle pulse regardless of Enable.
      listo_q <= 1'b0;
      if (!Enable) begin
        if (!Modo) begin
          // Plain load register; leaving frame mode abandons any partial frame.
          state_q <= IDLE;
          cnt_q   <= '0;
          if (Valid) begin
            reg_q   <= Suma;
            listo_q <= 1'b1;
          end
        end else if (acc) begin
          case (state_q)
            ACUM: begin
              reg_q <= sum_d;
              cnt_q <= cnt_d;
`ifdef REGISTRO_SAT_EN
              if (ovf_d) desborde_q <= 1'b1;
`endif
              if (cnt_d == M_CNT) begin
                state_q <= DONE;
                listo_q <= 1'b1;
              end
            end
            IDLE, DONE: begin
              // First sample of a new frame; a one-sample frame completes at once.
              reg_q <= Suma;
              cnt_q <= CW'(1);
              if (M == 1) begin
                state_q <= DONE;
                listo_q <= 1'b1;
              end else begin
                state_q <= ACUM;
              end
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign Signreg = reg_q;
  assign Cuenta  = cnt_q;
  assign Listo   = listo_q;

endmodule

// File: tb/tb_registro_acumulador.sv
// Self-checking bench for registro_acumulador (N=4, M=4) against a frame-queue reference model.
module tb_registro_acumulador;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 2 * N;
  localparam int CW = $clog2(M + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] Suma = '0;
  logic                 Valid = 1'b0;
  logic                 Enable = 1'b0;
  logic                 Modo = 1'b0;
  logic signed [DW-1:0] Signreg;
  logic [CW-1:0]        Cuenta;
  logic                 Listo;
  logic                 Desborde;

  registro_acumulador #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .Suma     (Suma),
    .Valid    (Valid),
    .Enable   (Enable),
    .Modo     (Modo),
    .Signreg  (Signreg),
    .Cuenta   (Cuenta),
    .Listo    (Listo),
    .Desborde (Desborde)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the samples of the open frame, folded with the sum rule.
  int                   frame[$];
  logic signed [DW-1:0] exp_reg   = '0;
  logic                 exp_listo = 1'b0;
  logic                 exp_desb  = 1'b0;
  logic [CW-1:0]        exp_cnt   = '0;
  logic [DW+CW+1:0]     exp_all;
  logic [DW+CW+1:0]     obs;

  assign obs = {Signreg, Cuenta, Listo, Desborde};

  function automatic void refold();
    int a;
    a = frame[0];
    for (int i = 1; i < frame.size(); i++) begin
      a = a + frame[i];
`ifdef REGISTRO_SAT_EN
      if (a > 127) begin a = 127; exp_desb = 1'b1; end
      else if (a < -128) begin a = -128; exp_desb = 1'b1; end
`else
      if (a > 127) a = a - 256;
      else if (a < -128) a = a + 256;
`endif
    end
    exp_reg = DW'(a);
  endfunction

  task automatic step(input bit r, input bit v, input bit e, input bit md,
                      input logic signed [DW-1:0] s);
    @(negedge clk);
    rst = r; Valid = v; Enable = e; Modo = md; Suma = s;
    exp_listo = 1'b0;
    if (r) begin
      frame.delete();
      exp_reg  = '0;
      exp_desb = 1'b0;
    end else if (!e) begin
      if (!md) begin
        frame.delete();
        if (v) begin exp_reg = s; exp_listo = 1'b1; end
      end else if (v) begin
        if (frame.size() == M) frame.delete();
        frame.push_back(int'(s));
        refold();
        exp_listo = (frame.size() == M);
      end
    end
    exp_cnt = CW'(frame.size());
    exp_all = {exp_reg, exp_cnt, exp_listo, exp_desb};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 1, 8'sd77);
    step(1, 1, 1, 0, -8'sd3);
    total++;
    if (obs !== {DW+CW+2{1'b0}}) begin
      bad++; $display("FAIL reset_zero got %h want 0", obs);
    end
    step(0, 0, 0, 1, 8'sd0);
    total++;
    if (obs !== exp_all) begin
      bad++; $display("FAIL reset_idle got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_load();
    step(1, 0, 0, 0, 8'sd0);
    step(0, 1, 0, 0, 8'sh25);
    total++;
    if (Signreg !== 8'sh25 || Listo !== 1'b1 || Cuenta !== '0) begin
      bad++; $display("FAIL load got reg=%h listo=%b cnt=%0d want 25 1 0", Signreg, Listo, Cuenta);
    end
    step(0, 0, 0, 0, 8'sd0);
    total++;
    if (obs !== exp_all || Listo !== 1'b0) begin
      bad++; $display("FAIL load_pulse got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_frame();
    logic signed [DW-1:0] smp [4] = '{8'sd10, 8'sd20, -8'sd5, 8'sd7};
    step(1, 0, 0, 1, 8'sd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1, smp[i]);
      total++;
      if (obs !== exp_all || Cuenta !== CW'(i + 1)) begin
        bad++; $display("FAIL frame_s%0d got %h want %h", i, obs, exp_all);
      end
    end
    total++;
    if (Signreg !== 8'sd32 || Listo !== 1'b1) begin
      bad++; $display("FAIL frame_sum got %0d/%b want 32/1", Signreg, Listo);
    end
    step(0, 1, 0, 1, 8'sd3);
    total++;
    if (Signreg !== 8'sd3 || Cuenta !== CW'(1) || Listo !== 1'b0) begin
      bad++; $display("FAIL frame_new got %0d/%0d/%b want 3/1/0", Signreg, Cuenta, Listo);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 1, 8'sd0);
    step(0, 1, 0, 1, 8'sd100);
    step(0, 1, 0, 1, 8'sd100);
    total++;
`ifdef REGISTRO_SAT_EN
    if (Signreg !== 8'sd127 || Desborde !== 1'b1) begin
      bad++; $display("FAIL ovf_sat got %0d/%b want 127/1", Signreg, Desborde);
    end
`else
    if (Signreg !== -8'sd56 || Desborde !== 1'b0) begin
      bad++; $display("FAIL ovf_wrap got %0d/%b want -56/0", Signreg, Desborde);
    end
`endif
    step(0, 1, 0, 1, 8'sd1);
    step(0, 1, 0, 0, 8'sd4);
    total++;
    if (obs !== exp_all) begin
      bad++; $display("FAIL ovf_sticky got %h want %h", obs, exp_all);
    end
    step(1, 0, 0, 0, 8'sd0);
    total++;
    if (Desborde !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got %b want 0", Desborde);
    end
  endtask

  task automatic test_enable_hold();
    step(1, 0, 0, 1, 8'sd0);
    step(0, 1, 0, 1, 8'sd5);
    step(0, 1, 0, 1, 8'sd6);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, DW'($urandom));
      total++;
      if (Signreg !== 8'sd11 || Cuenta !== CW'(2) || obs !== exp_all) begin
        bad++; $display("FAIL hold_%0d got %h want %h", i, obs, exp_all);
      end
    end
    step(0, 1, 0, 1, -8'sd2);
    step(0, 1, 0, 1, 8'sd9);
    total++;
    if (Signreg !== 8'sd18 || Listo !== 1'b1 || Cuenta !== CW'(M)) begin
      bad++; $display("FAIL hold_resume got %0d/%b/%0d want 18/1/4", Signreg, Listo, Cuenta);
    end
    step(0, 1, 1, 1, 8'sd50);
    total++;
    if (Listo !== 1'b0 || Cuenta !== CW'(M) || obs !== exp_all) begin
      bad++; $display("FAIL hold_pulse got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_reset_midframe();
    step(1, 0, 0, 1, 8'sd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'sd7);
    step(1, 1, 0, 1, 8'sd50);
    total++;
    if (obs !== {DW+CW+2{1'b0}}) begin
      bad++; $display("FAIL rst_mid got %h want 0", obs);
    end
    step(0, 1, 0, 1, 8'sd2);
    total++;
    if (Cuenta !== CW'(1) || Signreg !== 8'sd2 || Listo !== 1'b0) begin
      bad++; $display("FAIL rst_idle got %0d/%0d/%b want 1/2/0", Cuenta, Signreg, Listo);
    end
  endtask

  task automatic test_mode_switch();
    step(1, 0, 0, 1, 8'sd0);
    step(0, 1, 0, 1, 8'sd30);
    step(0, 1, 0, 1, 8'sd40);
    step(0, 1, 0, 0, 8'sd9);
    total++;
    if (Signreg !== 8'sd9 || Cuenta !== '0 || Listo !== 1'b1) begin
      bad++; $display("FAIL mode_10 got %0d/%0d/%b want 9/0/1", Signreg, Cuenta, Listo);
    end
    step(0, 1, 0, 1, 8'sd4);
    total++;
    if (Cuenta !== CW'(1) || Signreg !== 8'sd4 || obs !== exp_all) begin
      bad++; $display("FAIL mode_01 got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_random();
    bit md;
    md = 1'b1;
    step(1, 0, 0, 1, 8'sd0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 8) md = ~md;
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 20, md, DW'($urandom));
      total++;
      if (obs !== exp_all) begin
        bad++; $display("FAIL rand_%0d got %h want %h", i, obs, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_frame();
    test_overflow();
    test_enable_hold();
    test_reset_midframe();
    test_mode_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
